// File: rtl/uc_dispatch_sched.sv
// Dispatch scheduler: hands buffered unit clauses to ready BCP engines in
// round-robin order and sequences a run through quiescence or conflict.
module uc_dispatch_sched #(
  parameter int NUM_ENGINE   = 4,
  parameter int LIT_IDX_MAX  = 1024,
  parameter int CLA_LENGTH   = 3,
  parameter int QUIET_CYCLES = 3,
  localparam int VAR_W = $clog2(LIT_IDX_MAX) + 1,
  localparam int CW    = VAR_W * CLA_LENGTH,
  localparam int AW    = $clog2(NUM_ENGINE) + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_in,
  input  logic                       clear_in,
  input  logic [AW-1:0]              avail_in,
  input  logic [NUM_ENGINE*CW-1:0]   clause_in,
  input  logic                       empty_in,
  input  logic [NUM_ENGINE-1:0]      eng_ready_in,
  input  logic [NUM_ENGINE-1:0]      eng_conflict_in,
  output logic                       buf_start_out,
  output logic [AW-1:0]              clause_received_out,
  output logic [NUM_ENGINE-1:0]      eng_valid_out,
  output logic [NUM_ENGINE*CW-1:0]   eng_clause_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       conflict_out,
  output logic [1:0]                 state_out
);

  localparam int unsigned NE = NUM_ENGINE;
  localparam int PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int QW = $clog2(QUIET_CYCLES) + 1;
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [QW-1:0] QUIET_SAT  = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    CONFLICT = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           rr_ptr, rr_nxt;
  logic [QW-1:0]           quiet_cnt, quiet_nxt;
  logic [NUM_ENGINE-1:0]   grant;
  logic [NUM_ENGINE*CW-1:0] clause_nxt;
  logic [PW-1:0]           idx, last;
  logic [31:0]             n_grant, avail_eff;
  logic                    dispatch, quiet;

  // Grant walk: the j-th ready engine found from rr_ptr takes buffer slot j.
  always_comb begin
    grant      = '0;
    clause_nxt = eng_clause_out;
    n_grant    = '0;
    idx        = '0;
    last       = '0;
    avail_eff  = (32'(avail_in) > NE) ? NE : 32'(avail_in);
    dispatch   = (state == RUN) && !reset && (eng_conflict_in == '0);
    if (dispatch) begin
      for (int unsigned j = 0; j < NE; j++) begin
        idx = PW'((32'(rr_ptr) + j) % NE);
        if (eng_ready_in[idx] && (n_grant < avail_eff)) begin
          grant[idx]                 = 1'b1;
          clause_nxt[idx*CW +: CW]   = clause_in[n_grant*CW +: CW];
          n_grant                    = n_grant + 32'd1;
          last                       = idx;
        end
      end
    end
    clause_received_out = AW'(n_grant);
    rr_nxt = (n_grant != 0) ? PW'((32'(last) + 32'd1) % NE) : rr_ptr;
  end

  always_comb begin
    quiet = (state == RUN) && empty_in && (avail_in == '0) &&
            (&eng_ready_in) && (eng_valid_out == '0);
    if (!quiet)
      quiet_nxt = '0;
    else if (quiet_cnt == QUIET_SAT)
      quiet_nxt = quiet_cnt;
    else
      quiet_nxt = quiet_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_in) state_nxt = RUN;
      RUN: begin
        if (eng_conflict_in != '0)
          state_nxt = CONFLICT;
        else if (quiet && (quiet_cnt == QUIET_LAST))
          state_nxt = DONE;
      end
      DONE:     if (clear_in) state_nxt = IDLE;
      CONFLICT: if (clear_in) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      quiet_cnt      <= '0;
      eng_valid_out  <= '0;
      eng_clause_out <= '0;
    end else begin
      state          <= state_nxt;
      rr_ptr         <= rr_nxt;
      quiet_cnt      <= quiet_nxt;
      eng_valid_out  <= grant;
      eng_clause_out <= clause_nxt;
    end
  end

  assign buf_start_out = (state == RUN);
  assign busy_out      = (state == RUN);
  assign done_out      = (state == DONE);
  assign conflict_out  = (state == CONFLICT);
  assign state_out     = state;

endmodule

// File: tb/tb_uc_dispatch_sched.sv
// Scoreboarded bench for uc_dispatch_sched: directed grant vectors push the
// expected engine strobes; a negedge monitor pops and compares them.
module tb_uc_dispatch_sched;

  localparam int NE = 4;
  localparam int CW = 33;
  localparam int AW = 3;

  logic              clock;
  logic              reset;
  logic              start_in;
  logic              clear_in;
  logic [AW-1:0]     avail_in;
  logic [NE*CW-1:0]  clause_in;
  logic              empty_in;
  logic [NE-1:0]     eng_ready_in;
  logic [NE-1:0]     eng_conflict_in;
  logic              buf_start_out;
  logic [AW-1:0]     clause_received_out;
  logic [NE-1:0]     eng_valid_out;
  logic [NE*CW-1:0]  eng_clause_out;
  logic              busy_out, done_out, conflict_out;
  logic [1:0]        state_out;

  uc_dispatch_sched #(
    .NUM_ENGINE   (4),
    .LIT_IDX_MAX  (1024),
    .CLA_LENGTH   (3),
    .QUIET_CYCLES (3)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start_in            (start_in),
    .clear_in            (clear_in),
    .avail_in            (avail_in),
    .clause_in           (clause_in),
    .empty_in            (empty_in),
    .eng_ready_in        (eng_ready_in),
    .eng_conflict_in     (eng_conflict_in),
    .buf_start_out       (buf_start_out),
    .clause_received_out (clause_received_out),
    .eng_valid_out       (eng_valid_out),
    .eng_clause_out      (eng_clause_out),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .conflict_out        (conflict_out),
    .state_out           (state_out)
  );

  typedef struct packed {
    logic [NE-1:0]    mask;
    logic [NE*CW-1:0] cl;
  } exp_t;

  exp_t        q[$];
  logic [CW-1:0] hold [NE];
  int          n_vec = 0;
  int          n_err = 0;
  int          vid   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  function automatic logic [CW-1:0] cv(input int v, input int s);
    return {1'b1, 32'(v * 4096 + s * 256 + 90)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic st_chk(input string tag, input logic [1:0] st);
    chk({tag, "_state"},    64'(state_out),     64'(st));
    chk({tag, "_busy"},     64'(busy_out),      64'(st == 2'd1));
    chk({tag, "_bufstart"}, 64'(buf_start_out), 64'(st == 2'd1));
    chk({tag, "_done"},     64'(done_out),      64'(st == 2'd2));
    chk({tag, "_conflict"}, 64'(conflict_out),  64'(st == 2'd3));
  endtask

  task automatic fill(input int v);
    for (int s = 0; s < NE; s++) clause_in[s*CW +: CW] = cv(v, s);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One RUN cycle; sN is the buffer slot engine N should receive, -1 for none.
  task automatic apply(input int avail, input logic [NE-1:0] rdy, input int recv,
                       input int s0, input int s1, input int s2, input int s3);
    exp_t x;
    int   sl[NE];
    sl = '{s0, s1, s2, s3};
    avail_in     = AW'(avail);
    eng_ready_in = rdy;
    empty_in     = 1'b0;
    fill(vid);
    @(negedge clock);
    chk($sformatf("received_v%0d", vid), 64'(clause_received_out), 64'(recv));
    st_chk("run", 2'd1);
    x = '0;
    for (int e = 0; e < NE; e++)
      if (sl[e] >= 0) begin
        x.mask[e]        = 1'b1;
        x.cl[e*CW +: CW] = cv(vid, sl[e]);
      end
    if (x.mask != '0) q.push_back(x);
    tick();
    vid++;
  endtask

  task automatic quiet_cyc(input logic [1:0] st);
    avail_in     = '0;
    empty_in     = 1'b1;
    eng_ready_in = '1;
    @(negedge clock);
    chk("quiet_received", 64'(clause_received_out), 64'd0);
    st_chk("quiet", st);
    tick();
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (eng_valid_out != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(eng_valid_out), 64'd0);
      end else begin
        x = q.pop_front();
        chk("valid_mask", 64'(eng_valid_out), 64'(x.mask));
        for (int e = 0; e < NE; e++)
          if (x.mask[e]) hold[e] = x.cl[e*CW +: CW];
        for (int e = 0; e < NE; e++)
          chk($sformatf("eng%0d_clause", e), 64'(eng_clause_out[e*CW +: CW]), 64'(hold[e]));
      end
    end
    if (reset)
      for (int e = 0; e < NE; e++) hold[e] = '0;
  end

  initial begin
    reset = 1'b1; start_in = 1'b0; clear_in = 1'b0; avail_in = '0;
    clause_in = '0; empty_in = 1'b0; eng_ready_in = '1; eng_conflict_in = '0;
    for (int e = 0; e < NE; e++) hold[e] = '0;
    repeat (2) @(posedge clock);
    #1;
    avail_in = 3'd4;
    fill(99);
    @(negedge clock);
    chk("reset_received", 64'(clause_received_out), 64'd0);
    chk("reset_valid", 64'(eng_valid_out), 64'd0);
    chk("reset_clause", 64'(eng_clause_out != '0), 64'd0);
    st_chk("reset", 2'd0);
    tick();
    reset = 1'b0;

    // IDLE: clear ignored, nothing dispatched
    clear_in = 1'b1;
    @(negedge clock);
    chk("idle_received", 64'(clause_received_out), 64'd0);
    st_chk("idle", 2'd0);
    tick();
    clear_in = 1'b0;
    start_in = 1'b1;
    @(negedge clock);
    st_chk("idle_start", 2'd0);
    tick();
    start_in = 1'b0;

    apply(4, 4'b1111, 4,  0,  1,  2,  3);   // rr 0 -> 0
    apply(1, 4'b0010, 1, -1,  0, -1, -1);   // rr 0 -> 2
    apply(2, 4'b1010, 2, -1,  1, -1,  0);   // rr 2 -> 2
    apply(3, 4'b0001, 1,  0, -1, -1, -1);   // rr 2 -> 1
    apply(7, 4'b1111, 4,  3,  0,  1,  2);   // avail clamps to 4; rr 1 -> 1
    apply(0, 4'b1111, 0, -1, -1, -1, -1);
    apply(2, 4'b0000, 0, -1, -1, -1, -1);
    apply(2, 4'b1111, 2, -1,  0,  1, -1);   // rr 1 -> 3
    apply(3, 4'b1011, 3,  1,  2, -1,  0);   // rr 3 -> 2

    // Quiescence interrupted by a single grant, then three clean quiet cycles
    quiet_cyc(2'd1);
    quiet_cyc(2'd1);
    quiet_cyc(2'd1);
    apply(1, 4'b1111, 1, -1, -1,  0, -1);   // rr 2 -> 3
    quiet_cyc(2'd1);
    quiet_cyc(2'd1);
    quiet_cyc(2'd1);
    quiet_cyc(2'd1);

    avail_in = 3'd4; empty_in = 1'b0; start_in = 1'b1; fill(vid);
    @(negedge clock);
    chk("done_received", 64'(clause_received_out), 64'd0);
    st_chk("done", 2'd2);
    tick();
    start_in = 1'b0; clear_in = 1'b1;
    @(negedge clock);
    st_chk("done_hold", 2'd2);
    tick();
    clear_in = 1'b1;
    @(negedge clock);
    st_chk("idle_after_done", 2'd0);
    tick();
    clear_in = 1'b0; start_in = 1'b1;
    @(negedge clock);
    st_chk("idle_start2", 2'd0);
    tick();
    start_in = 1'b0;

    // Conflict beats a simultaneous full grant
    avail_in = 3'd4; eng_ready_in = '1; eng_conflict_in = 4'b0100; fill(vid);
    @(negedge clock);
    chk("conflict_received", 64'(clause_received_out), 64'd0);
    st_chk("conflict_cycle", 2'd1);
    tick();
    eng_conflict_in = '0; start_in = 1'b1;
    @(negedge clock);
    chk("conflict_state_received", 64'(clause_received_out), 64'd0);
    st_chk("conflict", 2'd3);
    tick();
    start_in = 1'b0; clear_in = 1'b1;
    @(negedge clock);
    st_chk("conflict_hold", 2'd3);
    tick();
    clear_in = 1'b0; start_in = 1'b1;
    @(negedge clock);
    st_chk("idle_after_conflict", 2'd0);
    tick();
    start_in = 1'b0;

    apply(1, 4'b1111, 1, -1, -1, -1,  0);   // rr 3 -> 0
    apply(1, 4'b1111, 1,  0, -1, -1, -1);   // rr 0 -> 1

    // Reset mid-run with a valid pending and a grantable request present
    reset = 1'b1; avail_in = 3'd4; eng_ready_in = '1; fill(vid);
    @(negedge clock);
    chk("midreset_received", 64'(clause_received_out), 64'd0);
    tick();
    reset = 1'b0; start_in = 1'b1;
    @(negedge clock);
    st_chk("after_reset", 2'd0);
    chk("after_reset_valid", 64'(eng_valid_out), 64'd0);
    chk("after_reset_clause", 64'(eng_clause_out != '0), 64'd0);
    chk("after_reset_received", 64'(clause_received_out), 64'd0);
    tick();
    start_in = 1'b0;
    apply(1, 4'b1111, 1,  0, -1, -1, -1);   // rr back at 0 after reset
    quiet_cyc(2'd1);
    tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uc_dispatch_sched.md
Name: uc_dispatch_sched

Overview:
- Scheduler between the unit-clause latency buffer and the NUM_ENGINE BCP engines.
- Each cycle it grants buffered clauses (buffer slots 0..avail-1) to ready engines in round-robin order.
- It returns the accepted count to the buffer so the buffer can advance its head pointer.
- It sequences the run: start, dispatch, quiescence detection (done) and conflict abort.

Parameters:
- NUM_ENGINE, 4, number of BCP engines and buffer output slots.
- LIT_IDX_MAX, 1024, literal index range. VAR_W = clog2(LIT_IDX_MAX)+1 = 11.
- CLA_LENGTH, 3, literals per clause. CW = VAR_W*CLA_LENGTH = 33.
- QUIET_CYCLES, 3, consecutive quiescent cycles required before done; covers the 1-cycle buffer input latency plus engine turnaround.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start_in  in  1  one-cycle pulse; begins a run
- clear_in  in  1  returns the block from DONE/CONFLICT to IDLE
- avail_in  in  clog2(NUM_ENGINE)+1  number of valid slots offered by the buffer; slots 0..avail_in-1 are valid
- clause_in  in  NUM_ENGINE x CW  buffer slot contents
- empty_in  in  1  buffer head==tail
- eng_ready_in  in  NUM_ENGINE  engine idle, can accept a clause this cycle
- eng_conflict_in  in  NUM_ENGINE  engine detected a conflict
- buf_start_out  out  1  enables buffer release; high only in RUN
- clause_received_out  out  clog2(NUM_ENGINE)+1  combinational count of slots consumed this cycle
- eng_valid_out  out  NUM_ENGINE  registered per-engine clause-valid strobe
- eng_clause_out  out  NUM_ENGINE x CW  registered clause for each engine
- busy_out, done_out, conflict_out  out  1 each  status flags
- state_out  out  2  IDLE=0, RUN=1, DONE=2, CONFLICT=3

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, quiet_cnt=0.
  - All outputs 0; eng_clause_out=0.
- IDLE:
  - received=0.
  - start_in -> RUN next cycle.
  - clear_in is ignored.
- RUN:
  - buf_start_out=1, busy_out=1.
  - k = min(avail_in, popcount(eng_ready_in)).
  - Walk engines from rr_ptr upward, wrapping modulo NUM_ENGINE. The j-th ready engine found (j<k) receives clause_in[j].
  - clause_received_out = k, same cycle (combinational).
  - Next cycle, granted engines have eng_valid_out=1 and eng_clause_out set. Non-granted engines have valid=0 and hold their last clause value. Latency: 1 cycle.
  - If k>0, rr_ptr <= (index of last granted engine)+1, mod NUM_ENGINE. Otherwise rr_ptr holds.
  - An engine with eng_ready_in=0 is never granted.
  - avail_in>NUM_ENGINE is treated as NUM_ENGINE.
- Quiescence:
  - A cycle is quiescent when, in RUN: empty_in=1, avail_in=0, eng_ready_in all 1, and no eng_valid_out is asserted.
  - quiet_cnt increments on a quiescent cycle and clears on any non-quiescent cycle.
  - quiet_cnt reaching QUIET_CYCLES-1 on a quiescent cycle -> DONE.
- Conflict:
  - Any eng_conflict_in bit in RUN -> CONFLICT next cycle. Priority is over both done and a simultaneous grant.
  - In that cycle received=0 and no new eng_valid_out is produced.
- DONE / CONFLICT:
  - buf_start_out=0, received=0, eng_valid_out=0.
  - done_out=1 (or conflict_out=1) held until clear_in -> IDLE.
  - start_in is ignored until clear_in.
- start_in while in RUN: ignored; no restart.
- reset mid-run: state returns to IDLE in one cycle and in-flight valids drop. received=0 in the reset cycle regardless of inputs.
- quiet_cnt width: clog2(QUIET_CYCLES)+1, saturating.

Test Plan:
- Reset, then start_in pulse, avail_in=4, all ready, rr_ptr=0 -> clause_received_out=4. Next cycle eng_valid_out=4'b1111, engine i gets clause_in[i], rr_ptr=0.
- RUN, avail_in=2, eng_ready_in=4'b1010, rr_ptr=2 -> received=2. Engine3 gets slot0, engine1 gets slot1, valid=4'b1010, rr_ptr=2.
- RUN, avail_in=3, eng_ready_in=4'b0001 -> received=1. Only engine0 valid, carrying clause_in[0]; rr_ptr=1.
- RUN, empty_in=1, avail_in=0, all ready for 3 cycles -> state_out=2, done_out=1, buf_start_out=0. A 1-cycle avail_in=1 after 2 quiet cycles restarts the count (done after 3 more).
- RUN, eng_conflict_in=4'b0100 together with avail_in=4, all ready -> received=0, no valids, next state CONFLICT, conflict_out=1. clear_in -> IDLE.
- Assert reset while valids are pending mid-RUN -> next cycle state=IDLE, all outputs 0, rr_ptr=0.
